// File: rtl/sevseg_frame_decoder_if.sv
// Bundle of the multiplexed seven-segment lines and the rebuilt frame outputs.
// Latency: none (wires only). Backpressure: none, the display bus cannot be stalled.
// master drives seg/an and reads results; slave is the decoder.
interface sevseg_frame_decoder_if;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits_out;
    logic [3:0]  blank_out;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  frame_count;
    logic        stale;

    modport master (
        output seg_in, an_in,
        input  digits_out, blank_out, frame_valid, frame_err, frame_count, stale
    );

    modport slave (
        input  seg_in, an_in,
        output digits_out, blank_out, frame_valid, frame_err, frame_count, stale
    );
endinterface

// File: rtl/sevseg_frame_decoder.sv
// Rebuilds the 4-digit BCD frame from multiplexed active-low seg/an lines for readback.
// Latency: 2-cycle synchronizer + SETTLE_CYCLES dwell per digit; frame lands 1 cycle after the last capture.
// Backpressure: none; frame_valid is a one-cycle pulse and outputs hold until the next frame.
module sevseg_frame_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  reset,
    sevseg_frame_decoder_if.slave bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [6:0]       seg_m, seg_s, seg_p;
    logic [3:0]       an_m, an_s, an_p;
    logic [SW-1:0]    settle_q;
    logic [TW-1:0]    timeout_q;

    logic [3:0][3:0]  slot_q, slot_d;
    logic [3:0]       sblank_q, sblank_d;
    logic [3:0]       serr_q, serr_d;
    logic [3:0]       seen_q, seen_d;

    logic [15:0]      digits_q;
    logic [3:0]       blank_q;
    logic             frame_valid_q;
    logic             frame_err_q;
    logic [7:0]       frame_count_q;
    logic             stale_q;

    logic             changed;
    logic             onehot;
    logic [1:0]       idx;
    logic             capture;
    logic             complete;
    logic [3:0]       dec_val;
    logic             dec_blank;
    logic             dec_err;

    assign changed = {an_s, seg_s} != {an_p, seg_p};
    // Fires once per stable dwell: the counter only passes SETTLE_CYCLES-1 once before saturating.
    assign capture = onehot && !changed && (settle_q == SW'(SETTLE_CYCLES - 1));

    always_comb begin
        onehot = 1'b1;
        idx    = 2'd0;
        case (an_s)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
    end

    always_comb begin
        dec_val   = 4'hE;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_s)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: begin
                dec_val   = 4'hF;
                dec_blank = 1'b1;
            end
            default:    dec_err = 1'b1;
        endcase
    end

    always_comb begin
        slot_d   = slot_q;
        sblank_d = sblank_q;
        serr_d   = serr_q;
        seen_d   = seen_q;
        if (capture) begin
            slot_d[idx]   = dec_val;
            sblank_d[idx] = dec_blank;
            serr_d[idx]   = dec_err;
            seen_d[idx]   = 1'b1;
        end
        complete = capture && (seen_d == 4'b1111);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_m         <= '0;
            seg_s         <= '0;
            seg_p         <= '0;
            an_m          <= '0;
            an_s          <= '0;
            an_p          <= '0;
            settle_q      <= '0;
            timeout_q     <= '0;
            slot_q        <= '0;
            sblank_q      <= '0;
            serr_q        <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            blank_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
            stale_q       <= 1'b0;
        end else begin
            seg_m <= bus.seg_in;
            seg_s <= seg_m;
            seg_p <= seg_s;
            an_m  <= bus.an_in;
            an_s  <= an_m;
            an_p  <= an_s;

            if (changed)
                settle_q <= '0;
            else if (settle_q != SW'(SETTLE_CYCLES))
                settle_q <= settle_q + 1'b1;

            slot_q        <= slot_d;
            sblank_q      <= sblank_d;
            serr_q        <= serr_d;
            seen_q        <= complete ? 4'b0000 : seen_d;
            frame_valid_q <= complete;

            // A completing frame takes priority over the timeout reaching its limit.
            if (complete) begin
                digits_q      <= slot_d;
                blank_q       <= sblank_d;
                frame_err_q   <= |serr_d;
                frame_count_q <= frame_count_q + 8'd1;
                timeout_q     <= '0;
                stale_q       <= 1'b0;
            end else begin
                if (timeout_q != TW'(TIMEOUT_CYCLES))
                    timeout_q <= timeout_q + 1'b1;
                if (timeout_q == TW'(TIMEOUT_CYCLES - 1))
                    stale_q <= 1'b1;
            end
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.blank_out   = blank_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_count = frame_count_q;
    assign bus.stale       = stale_q;
endmodule
